// File: rtl/mux_scan_deserializer.sv
// Scans the 16:1 select tree channel by channel and packs the samples into a word with valid/ready.
// Optional MUX_SCAN_PARITY_EN adds a registered parity output over the scanned channels.
module mux_scan_deserializer #(
    parameter int LAST_CH    = 15,
    parameter int SETTLE_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mux_out,
    output logic [3:0]  sel,
    output logic        busy,
    output logic [15:0] data,
    output logic        data_valid,
    input  logic        out_ready
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic        parity
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] LAST_SEL = 4'(LAST_CH);
    // With no settle time the counter is never consulted, so load 0 rather than underflow.
    localparam logic [3:0] CNT_LOAD = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);
    localparam state_t     AFTER_SEL = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;

    state_t      r_state;
    logic [3:0]  r_sel;
    logic [3:0]  r_cnt;
    logic [15:0] r_data;
    logic        r_valid;
    logic        r_busy;

    state_t      w_state_next;
    logic [3:0]  w_sel_next;
    logic [3:0]  w_cnt_next;
    logic [15:0] w_data_next;
    logic        w_valid_next;

`ifdef MUX_SCAN_PARITY_EN
    logic r_parity;
    logic w_parity_next;
`endif

    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_cnt_next   = r_cnt;
        w_data_next  = r_data;
        w_valid_next = r_valid;
`ifdef MUX_SCAN_PARITY_EN
        w_parity_next = r_parity;
`endif
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_sel_next   = 4'd0;
                    w_data_next  = 16'd0;
                    w_cnt_next   = CNT_LOAD;
                    w_state_next = AFTER_SEL;
                end
            end
            SETTLE: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = SAMPLE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            SAMPLE: begin
                w_data_next[r_sel] = mux_out;
                if (r_sel == LAST_SEL) begin
                    w_state_next = DONE;
                    w_valid_next = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                    // Unscanned bits were cleared at start, so the full-word XOR is the scanned XOR.
                    w_parity_next = ^w_data_next;
`endif
                end else begin
                    w_sel_next   = r_sel + 4'd1;
                    w_cnt_next   = CNT_LOAD;
                    w_state_next = AFTER_SEL;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_valid_next = 1'b0;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= 4'd0;
            r_cnt   <= 4'd0;
            r_data  <= 16'd0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sel   <= w_sel_next;
            r_cnt   <= w_cnt_next;
            r_data  <= w_data_next;
            r_valid <= w_valid_next;
            r_busy  <= (w_state_next != IDLE);
        end
    end

`ifdef MUX_SCAN_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= w_parity_next;
        end
    end
    assign parity = r_parity;
`endif

    assign sel        = r_sel;
    assign busy       = r_busy;
    assign data       = r_data;
    assign data_valid = r_valid;

endmodule

// File: tb/tb_mux_scan_deserializer.sv
// Directed bench for mux_scan_deserializer: default instance (A) and LAST_CH=3/SETTLE_CYC=0 instance (B).
module tb_mux_scan_deserializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, ready_a = 1'b0;
    logic [15:0] pat_a = 16'd0;
    logic        mux_a, busy_a, valid_a;
    logic [3:0]  sel_a;
    logic [15:0] data_a;

    logic        start_b = 1'b0, ready_b = 1'b0;
    logic [15:0] pat_b = 16'd0;
    logic        mux_b, busy_b, valid_b;
    logic [3:0]  sel_b;
    logic [15:0] data_b;

`ifdef MUX_SCAN_PARITY_EN
    logic parity_a, parity_b;
`endif

    assign mux_a = pat_a[sel_a];
    assign mux_b = pat_b[sel_b];

    mux_scan_deserializer #(.LAST_CH(15), .SETTLE_CYC(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .mux_out(mux_a),
        .sel(sel_a), .busy(busy_a), .data(data_a), .data_valid(valid_a),
        .out_ready(ready_a)
`ifdef MUX_SCAN_PARITY_EN
        , .parity(parity_a)
`endif
    );

    mux_scan_deserializer #(.LAST_CH(3), .SETTLE_CYC(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mux_out(mux_b),
        .sel(sel_b), .busy(busy_b), .data(data_b), .data_valid(valid_b),
        .out_ready(ready_b)
`ifdef MUX_SCAN_PARITY_EN
        , .parity(parity_b)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advances edges until A's data_valid is seen; n is the number of edges taken (limit on timeout).
    task automatic wait_valid_a(input int limit, output int n);
        n = 0;
        while (valid_a !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        #3;
        tests++;
        if (sel_a !== 4'd0 || data_a !== 16'd0 || valid_a !== 1'b0 || busy_a !== 1'b0) begin
            fails++;
            $display("FAIL reset_a: sel=%0d data=%h valid=%b busy=%b, need all 0", sel_a, data_a, valid_a, busy_a);
        end
        tests++;
        if (sel_b !== 4'd0 || data_b !== 16'd0 || valid_b !== 1'b0 || busy_b !== 1'b0) begin
            fails++;
            $display("FAIL reset_b: sel=%0d data=%h valid=%b busy=%b, need all 0", sel_b, data_b, valid_b, busy_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        $display("[TB] reset checked");
    endtask

    task automatic test_basic_scan();
        int n;
        pat_a = 16'hA5C3;
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tests++;
        if (busy_a !== 1'b1 || sel_a !== 4'd0) begin
            fails++;
            $display("FAIL basic_start: busy=%b sel=%0d, need busy=1 sel=0", busy_a, sel_a);
        end
        n = 0;
        while (valid_a !== 1'b1 && n < 100) begin
            tick();
            n++;
            if (valid_a !== 1'b1 && n < 32) begin
                tests++;
                if (sel_a !== 4'(n / 2)) begin
                    fails++;
                    $display("FAIL basic_sel: edge %0d sel=%0d, need %0d", n, sel_a, n / 2);
                end
            end
        end
        tests++;
        if (n !== 32) begin
            fails++;
            $display("FAIL basic_latency: %0d edges after start, need 32", n);
        end
        tests++;
        if (data_a !== 16'hA5C3) begin
            fails++;
            $display("FAIL basic_data: data=%h, need a5c3", data_a);
        end
        tick();
        tests++;
        if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
            fails++;
            $display("FAIL basic_accept: valid=%b busy=%b, need 0 0", valid_a, busy_a);
        end
        $display("[TB] basic scan a5c3 latency=%0d data=%h", n, 16'hA5C3);
    endtask

    task automatic test_hold();
        int n;
        ready_a = 1'b0;
        pat_a = 16'h5A3C;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_valid_a(100, n);
        tests++;
        if (n !== 32) begin
            fails++;
            $display("FAIL hold_latency: %0d edges, need 32", n);
        end
        for (int i = 0; i < 10; i++) begin
            start_a = (i % 2 == 1);
            tick();
            tests++;
            if (valid_a !== 1'b1 || data_a !== 16'h5A3C || busy_a !== 1'b1) begin
                fails++;
                $display("FAIL hold_stable: cycle %0d valid=%b data=%h busy=%b, need 1 5a3c 1", i, valid_a, data_a, busy_a);
            end
        end
        start_a = 1'b0;
        ready_a = 1'b1;
        tick();
        tests++;
        if (valid_a !== 1'b0 || busy_a !== 1'b0 || data_a !== 16'h5A3C) begin
            fails++;
            $display("FAIL hold_accept: valid=%b busy=%b data=%h, need 0 0 5a3c", valid_a, busy_a, data_a);
        end
        ready_a = 1'b0;
        tick();
        tick();
        tests++;
        if (busy_a !== 1'b0) begin
            fails++;
            $display("FAIL hold_no_queue: busy=%b, need 0", busy_a);
        end
        $display("[TB] hold 10 cycles with start pulses, data=%h", 16'h5A3C);
    endtask

    task automatic test_short_scan();
        int n;
        pat_b = 16'hFFFF;
        ready_b = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        while (valid_b !== 1'b1 && n < 20) begin
            tick();
            n++;
            tests++;
            if (sel_b > 4'd3) begin
                fails++;
                $display("FAIL short_sel_range: sel=%0d, need <= 3", sel_b);
            end
        end
        tests++;
        if (n !== 4) begin
            fails++;
            $display("FAIL short_latency: %0d edges, need 4", n);
        end
        tests++;
        if (data_b !== 16'h000F || sel_b !== 4'd3) begin
            fails++;
            $display("FAIL short_data: data=%h sel=%0d, need 000f 3", data_b, sel_b);
        end
        tick();
        tests++;
        if (valid_b !== 1'b0) begin
            fails++;
            $display("FAIL short_accept: valid=%b, need 0", valid_b);
        end
        $display("[TB] short scan ffff -> data=%h latency=%0d", data_b, n);
    endtask

    task automatic test_reset_mid_scan();
        logic seen;
        pat_a = 16'hFFFF;
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (10) tick();
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (sel_a !== 4'd0 || data_a !== 16'd0 || valid_a !== 1'b0 || busy_a !== 1'b0) begin
            fails++;
            $display("FAIL midreset_clear: sel=%0d data=%h valid=%b busy=%b, need all 0", sel_a, data_a, valid_a, busy_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (valid_a === 1'b1) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0 || busy_a !== 1'b0) begin
            fails++;
            $display("FAIL midreset_quiet: valid_seen=%b busy=%b, need 0 0", seen, busy_a);
        end
        $display("[TB] reset mid-scan discarded word");
    endtask

    task automatic test_back_to_back();
        int n1, n2;
        pat_a = 16'h0001;
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        wait_valid_a(100, n1);
        tests++;
        if (n1 !== 32 || data_a !== 16'h0001) begin
            fails++;
            $display("FAIL b2b_first: latency=%0d data=%h, need 32 0001", n1, data_a);
        end
        pat_a = 16'h8000;
        tick();
        tests++;
        if (valid_a !== 1'b0) begin
            fails++;
            $display("FAIL b2b_drop: valid=%b, need 0", valid_a);
        end
        wait_valid_a(100, n2);
        tests++;
        if (n2 + 1 !== 34) begin
            fails++;
            $display("FAIL b2b_spacing: %0d edges between words, need 34", n2 + 1);
        end
        tests++;
        if (data_a !== 16'h8000) begin
            fails++;
            $display("FAIL b2b_second: data=%h, need 8000", data_a);
        end
        start_a = 1'b0;
        tick();
        tick();
        tests++;
        if (busy_a !== 1'b0 || valid_a !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle: busy=%b valid=%b, need 0 0", busy_a, valid_a);
        end
        $display("[TB] back-to-back words 0001 then 8000, spacing=%0d", n2 + 1);
    endtask

`ifdef MUX_SCAN_PARITY_EN
    task automatic test_parity();
        int n;
        logic [15:0] pats [2] = '{16'h0007, 16'h0003};
        logic        exp_par [2] = '{1'b1, 1'b0};
        ready_a = 1'b1;
        for (int i = 0; i < 2; i++) begin
            pat_a = pats[i];
            start_a = 1'b1;
            tick();
            start_a = 1'b0;
            wait_valid_a(100, n);
            tests++;
            if (data_a !== pats[i] || parity_a !== exp_par[i]) begin
                fails++;
                $display("FAIL parity: data=%h parity=%b, need %h %b", data_a, parity_a, pats[i], exp_par[i]);
            end
            tick();
            $display("[TB] parity scan %h -> parity=%b", pats[i], parity_a);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_scan();
        test_hold();
        test_short_scan();
        test_reset_mid_scan();
        test_back_to_back();
`ifdef MUX_SCAN_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
